// File: rtl/ballot_unit.sv
// ballot_unit: arms one vote per Ballot_en, debounces a single candidate key and casts it once.
// Define BALLOT_TIMEOUT_EN to compile in the armed-window timeout that forces LOCK.
module ballot_unit #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Ballot_en,
    input  logic [14:0] Btn,
    output logic [3:0]  IN,
    output logic        Vote_valid,
    output logic        Ready,
    output logic        Multi_err,
    output logic [11:0] Vote_cnt
);
    typedef enum logic [2:0] {IDLE, ARMED, DEBOUNCE, CAST, LOCK} state_t;

    state_t      state, state_nx;
    logic        rst_meta, rst_sync_n;
    logic [7:0]  deb_cnt, deb_cnt_nx;
    logic [3:0]  code, code_nx, key_code;
    logic [14:0] held_mask;
    logic        single, multi, multi_armed, multi_prev, tmo_hit;
    logic [3:0]  in_nx;
    logic        vv_nx, ready_nx, me_nx;
    logic [11:0] cnt_nx;

    // Assertion takes effect at once; release passes two flops so the FSM starts on a clean edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    always_comb begin
        key_code = '0;
        for (int unsigned i = 0; i < 15; i++)
            if (Btn[i]) key_code = 4'(i + 1);
    end

    assign single    = (Btn != '0) && ((Btn & (Btn - 15'd1)) == '0);
    assign multi     = (Btn != '0) && !single;
    assign held_mask = (code == '0) ? '0 : (15'(1) << (code - 4'd1));

`ifdef BALLOT_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (state == ARMED || state == DEBOUNCE)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign tmo_hit = (state == ARMED || state == DEBOUNCE) && (tmo_cnt == 16'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state      <= IDLE;
            deb_cnt    <= '0;
            code       <= '0;
            multi_prev <= 1'b0;
            IN         <= '0;
            Vote_valid <= 1'b0;
            Ready      <= 1'b0;
            Multi_err  <= 1'b0;
            Vote_cnt   <= '0;
        end else begin
            state      <= state_nx;
            deb_cnt    <= deb_cnt_nx;
            code       <= code_nx;
            multi_prev <= multi_armed;
            IN         <= in_nx;
            Vote_valid <= vv_nx;
            Ready      <= ready_nx;
            Multi_err  <= me_nx;
            Vote_cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        deb_cnt_nx = '0;
        code_nx    = code;
        case (state)
            IDLE:
                if (Ballot_en && Btn == '0) state_nx = ARMED;
            ARMED, DEBOUNCE: begin
                if (!Ballot_en)
                    state_nx = IDLE;
                else if (tmo_hit)
                    state_nx = LOCK;
                else if (state == ARMED) begin
                    if (single) begin
                        state_nx = DEBOUNCE;
                        code_nx  = key_code;
                    end
                end else if (Btn != held_mask)
                    state_nx = ARMED;
                else if (deb_cnt == 8'(DEB_CYCLES - 1))
                    state_nx = CAST;
                else
                    deb_cnt_nx = deb_cnt + 8'd1;
            end
            CAST:
                state_nx = LOCK;
            LOCK:
                if (Btn == '0 && !Ballot_en) state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    // Vote outputs are taken from the CAST state itself, so they appear one edge after CAST is entered.
    always_comb begin
        multi_armed = (state == ARMED) && multi;
        me_nx       = multi_armed && !multi_prev;
        vv_nx       = (state == CAST);
        in_nx       = (state == CAST) ? code : '0;
        cnt_nx      = (state == CAST && Vote_cnt != '1) ? Vote_cnt + 12'd1 : Vote_cnt;
        ready_nx    = (state_nx == ARMED);
    end

endmodule

// File: tb/tb_ballot_unit.sv
// tb_ballot_unit: directed ballot scenarios plus randomized key/enable traffic checked every cycle
// against a behavioural vote model; honours BALLOT_TIMEOUT_EN the same way as the design.
module tb_ballot_unit;
    localparam int DEB = 4;
    localparam int TMO = 16;
`ifdef BALLOT_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Ballot_en = 1'b0;
    logic [14:0] Btn = '0;
    logic [3:0]  IN;
    logic        Vote_valid, Ready, Multi_err;
    logic [11:0] Vote_cnt;

    int total = 0;
    int bad   = 0;

    ballot_unit #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Ballot_en (Ballot_en),
        .Btn       (Btn),
        .IN        (IN),
        .Vote_valid(Vote_valid),
        .Ready     (Ready),
        .Multi_err (Multi_err),
        .Vote_cnt  (Vote_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: window = armed or debouncing, hold = consecutive samples of the same single key.
    bit  m_win = 0, m_pend = 0, m_lock = 0, m_cprev = 0, m_cond = 0;
    int  m_hold = 0, m_age = 0, m_sync = 0, m_code = 0, m_cnt = 0, m_nb = 0;
    int  e_in = 0;
    bit  e_vv = 0, e_rdy = 0, e_me = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_win = 0; m_pend = 0; m_lock = 0; m_cprev = 0;
            m_hold = 0; m_age = 0; m_code = 0; m_cnt = 0; m_sync = 0;
            e_in = 0; e_vv = 0; e_rdy = 0; e_me = 0;
        end else if (m_sync < 2) begin
            m_sync++;
        end else begin
            m_nb   = $countones(Btn);
            e_vv   = 0;
            e_in   = 0;
            m_cond = m_win && m_hold == 0 && m_nb > 1;
            e_me   = m_cond && !m_cprev;
            m_cprev = m_cond;
            if (m_pend) begin
                e_vv = 1;
                e_in = m_code;
                if (m_cnt < 4095) m_cnt++;
                m_pend = 0;
                m_lock = 1;
            end else if (m_lock) begin
                if (Btn == 0 && !Ballot_en) m_lock = 0;
            end else if (!m_win) begin
                if (Ballot_en && Btn == 0) begin
                    m_win = 1; m_hold = 0; m_age = 0;
                end
            end else if (!Ballot_en) begin
                m_win = 0; m_hold = 0;
            end else if (TMO_ON && m_age == TMO - 1) begin
                m_win = 0; m_hold = 0; m_lock = 1;
            end else begin
                m_age++;
                if (m_hold == 0) begin
                    if (m_nb == 1) begin
                        for (int k = 0; k < 15; k++) if (Btn[k]) m_code = k + 1;
                        m_hold = 1;
                    end
                end else if (Btn != (15'(1) << (m_code - 1))) begin
                    m_hold = 0;
                end else begin
                    m_hold++;
                    if (m_hold == DEB + 1) begin
                        m_pend = 1; m_win = 0; m_hold = 0;
                    end
                end
            end
            e_rdy = m_win && m_hold == 0;
        end
    end

    always @(negedge clk) begin
        check("cyc_in", int'(IN), e_in);
        check("cyc_vote_valid", int'(Vote_valid), int'(e_vv));
        check("cyc_ready", int'(Ready), int'(e_rdy));
        check("cyc_multi_err", int'(Multi_err), int'(e_me));
        check("cyc_vote_cnt", int'(Vote_cnt), m_cnt);
    end

    int n_vv, lat, seg_len, kind, a, b;

    initial begin
        repeat (2) tick();
        check("rst_in", int'(IN), 0);
        check("rst_vv", int'(Vote_valid), 0);
        check("rst_ready", int'(Ready), 0);
        check("rst_cnt", int'(Vote_cnt), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Single key held 10 cycles: one vote for code 5, DEB+1 cycles after the press.
        Ballot_en = 1'b1;
        tick();
        check("s1_ready_armed", int'(Ready), 1);
        Btn = 15'h0010;
        n_vv = 0; lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (Vote_valid) begin
                n_vv++;
                if (lat < 0) lat = i - 1;
                check("s1_in", int'(IN), 5);
            end
        end
        check("s1_latency", lat, DEB + 1);
        check("s1_vote_count", n_vv, 1);
        check("s1_cnt", int'(Vote_cnt), 1);
        check("s1_ready_lock", int'(Ready), 0);

        // Still enabled after the cast: stay locked until both key and enable are low.
        Btn = '0;
        repeat (3) tick();
        check("s2_still_lock", int'(Ready), 0);
        Ballot_en = 1'b0;
        tick();
        Ballot_en = 1'b1;
        tick();
        check("s2_rearmed", int'(Ready), 1);

        // Short press then release: no vote, back to armed.
        Btn = 15'h0004;
        n_vv = 0;
        repeat (2) begin tick(); n_vv += int'(Vote_valid); end
        Btn = '0;
        tick();
        n_vv += int'(Vote_valid);
        check("s3_no_vote", n_vv, 0);
        check("s3_ready", int'(Ready), 1);

        // Two keys together: one Multi_err pulse, then key 15 alone is cast.
        Btn = 15'h4001;
        tick();
        check("s4_multi_pulse", int'(Multi_err), 1);
        tick();
        check("s4_multi_once", int'(Multi_err), 0);
        check("s4_no_vote", int'(Vote_valid), 0);
        Btn = 15'h4000;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick();
            if (Vote_valid) begin
                lat = i;
                check("s4_in", int'(IN), 15);
            end
        end
        check("s4_vote_seen", int'(lat > 0), 1);
        check("s4_cnt", int'(Vote_cnt), 2);
        check("s4_model_cnt", m_cnt, 2);
        Btn = '0;
        Ballot_en = 1'b0;
        repeat (2) tick();

        // Armed with no key: times out at the 16th armed cycle only when the timeout is built in.
        Ballot_en = 1'b1;
        tick();
        repeat (15) tick();
        check("s5_ready_before", int'(Ready), 1);
        tick();
        check("s5_ready_after", int'(Ready), TMO_ON ? 0 : 1);
        check("s5_cnt", int'(Vote_cnt), 2);
        Ballot_en = 1'b0;
        repeat (2) tick();

        // Reset during debounce: outputs clear at once and the pending press never votes.
        Ballot_en = 1'b1;
        tick();
        Btn = 15'h0008;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("s6_in", int'(IN), 0);
        check("s6_vv", int'(Vote_valid), 0);
        check("s6_ready", int'(Ready), 0);
        check("s6_me", int'(Multi_err), 0);
        check("s6_cnt", int'(Vote_cnt), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        n_vv = 0;
        repeat (10) begin tick(); n_vv += int'(Vote_valid); end
        check("s6_no_vote", n_vv, 0);
        Btn = '0;
        Ballot_en = 1'b0;
        repeat (2) tick();

        // Randomized key/enable traffic.
        for (int s = 0; s < 500; s++) begin
            seg_len = $urandom_range(1, 9);
            kind    = $urandom_range(0, 9);
            Ballot_en = ($urandom_range(0, 4) != 0);
            if (kind < 3) Btn = '0;
            else if (kind < 8) Btn = 15'(1) << $urandom_range(0, 14);
            else begin
                a = $urandom_range(0, 14);
                b = (a + 1 + $urandom_range(0, 13)) % 15;
                Btn = (15'(1) << a) | (15'(1) << b);
            end
            repeat (seg_len) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ballot_unit.md
BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 Parameter DEB_CYCLES, default 4: number of consecutive stable cycles required for a key press to be accepted (legal range 2..255).
REQ-002 Parameter TIMEOUT, default 1024: number of ARMED/DEBOUNCE cycles allowed before an armed ballot expires (legal range 16..65535).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 Ballot_en  input  1  level from the control unit that arms one vote.
REQ-006 Btn  input  15  raw candidate keys; Btn[k] high selects candidate code k+1.
REQ-007 IN  output  4  candidate code presented to the control unit; 0 means no vote.
REQ-008 Vote_valid  output  1  one-cycle strobe marking IN as a cast vote.
REQ-009 Ready  output  1  lamp; high while the unit is armed and waiting for a key.
REQ-010 Multi_err  output  1  one-cycle pulse when more than one key is seen while armed.
REQ-011 Vote_cnt  output  12  number of votes cast since reset; saturates at 4095.

Function
REQ-012 The FSM SHALL have five states: IDLE, ARMED, DEBOUNCE, CAST and LOCK, and SHALL enter IDLE on reset.
REQ-013 IDLE: when Ballot_en=1 and Btn=0, the next state SHALL be ARMED; otherwise the FSM stays in IDLE.
REQ-014 ARMED: Ready SHALL be 1; exactly one Btn bit high captures code k+1 and moves to DEBOUNCE with the debounce counter at 0.
REQ-015 ARMED: more than one Btn bit high SHALL pulse Multi_err for one cycle per rising edge of the multi-key condition, and the FSM stays in ARMED.
REQ-016 DEBOUNCE: while the same single key is held, the counter increments by 1; on reaching DEB_CYCLES-1 the next state SHALL be CAST.
REQ-017 DEBOUNCE: any change of Btn (release, other key, or added key) SHALL return the FSM to ARMED and clear the counter; no vote is cast.
REQ-018 CAST: lasts exactly one cycle; IN = captured code, Vote_valid = 1, and Vote_cnt increments unless already 4095.
REQ-019 LOCK: IN=0 and Ready=0; the FSM returns to IDLE only when Btn=0 and Ballot_en=0 in the same cycle, so one arm yields at most one vote.
REQ-020 Ballot_en=0 in ARMED or DEBOUNCE SHALL abort to IDLE the next cycle with no vote; Ballot_en is ignored in CAST.
REQ-021 IN SHALL be 0 in every state except CAST, and a code of 0 SHALL never accompany Vote_valid=1.
REQ-022 Latency from the first cycle a single key is sampled in ARMED to Vote_valid SHALL be DEB_CYCLES+1 cycles.
REQ-023 All outputs SHALL be registered; no combinational path from Btn or Ballot_en to any output.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, IN=0, Vote_valid=0, Ready=0, Multi_err=0, Vote_cnt=0, and clear the debounce and timeout counters and the captured code.
REQ-025 Reset asserted in any state, including CAST, SHALL suppress any pending vote; release is synchronised so that the first active edge after deassertion sees IDLE.

Configuration
REQ-026 The macro BALLOT_TIMEOUT_EN SHALL compile in a 16-bit timeout counter that clears on entry to ARMED from IDLE and counts in ARMED and DEBOUNCE.
REQ-027 With BALLOT_TIMEOUT_EN defined, reaching TIMEOUT-1 SHALL force LOCK with no vote cast, so Ballot_en must drop before re-arming.
REQ-028 Without BALLOT_TIMEOUT_EN, no timeout logic SHALL exist, and ARMED waits indefinitely.

Verification
REQ-029 Ballot_en=1, then Btn[4] held 10 cycles -> exactly one Vote_valid with IN=5, DEB_CYCLES+1 cycles after the press, then LOCK.
REQ-030 Btn[2] held 2 cycles, then released, with DEB_CYCLES=4 -> no Vote_valid and the FSM back in ARMED with Ready=1.
REQ-031 Btn[0] and Btn[14] pressed together -> one Multi_err pulse, no vote; a subsequent Btn[14] alone -> IN=15 cast.
REQ-032 Key held and Ballot_en kept 1 after a cast -> no second vote until both Btn=0 and Ballot_en=0, then a re-arm gives a second vote, and Vote_cnt=2.
REQ-033 With BALLOT_TIMEOUT_EN and TIMEOUT=16, armed with no key for 16 cycles -> LOCK, Vote_cnt unchanged; without the macro -> stays in ARMED.
REQ-034 rst_n pulsed low during DEBOUNCE -> all outputs 0 immediately and no Vote_valid afterwards.
